sram_rd_resp_pipe: RTL and testbench
====================================

Name: sram_rd_resp_pipe

Overview:
- Request/response front end for the 1024x32 byte-masked dual-port SRAM macro (one W0 port, one R0 port, one-cycle registered read address).
- Converts the macro's fixed-latency, non-stallable read port into a valid/ready request stream and a valid/ready response stream.
- A credit-limited 2-entry response FIFO makes back-pressure lossless and allows one read per cycle.
- Also forwards a fire-and-forget byte-masked write stream to the W0 port.

Parameters:
- ADDR_W, 10, SRAM word address width (1024 entries).
- DATA_W, 32, SRAM word width; must be a multiple of 8.
- MASK_W, DATA_W/8, byte-enable width.

Ports:
- clock  input  1  single clock; tied externally to both mem W0_clk and R0_clk.
- reset  input  1  synchronous, active-low reset.
- req_valid  input  1  read request valid.
- req_ready  output  1  read request accepted when req_valid && req_ready.
- req_addr  input  ADDR_W  read word address.
- resp_valid  output  1  response data valid.
- resp_ready  input  1  consumer accepts response.
- resp_data  output  DATA_W  read data, returned in request order.
- wr_valid  input  1  write strobe; always accepted, no ready.
- wr_addr  input  ADDR_W  write word address.
- wr_data  input  DATA_W  write data.
- wr_mask  input  MASK_W  byte enables.
- mem_W0_en, mem_W0_addr, mem_W0_data, mem_W0_mask  output  1/ADDR_W/DATA_W/MASK_W  to macro W0 port.
- mem_R0_en, mem_R0_addr  output  1/ADDR_W  to macro R0 port.
- mem_R0_data  input  DATA_W  from macro R0 port.

Behaviour:
- Write path is combinational pass-through: mem_W0_en=wr_valid, addr/data/mask wired straight through. Write reaches the array at the clock edge ending the cycle.
- Read issue: fire = req_valid && req_ready. mem_R0_en=fire and mem_R0_addr=req_addr, both combinational.
- inflight flag is a register: next value = fire. mem_R0_data is sampled only in the cycle where inflight=1 (request cycle N, capture at the end of N+1).
- Captured data is pushed into a 2-entry FIFO (occ 0..2). Head of the FIFO drives resp_data; resp_valid = (occ != 0).
- pop = resp_valid && resp_ready.
- Credit rule: req_ready = (occ + inflight - pop) < 2, a combinational path from resp_ready.
- Invariant: occ + inflight <= 2 at all times. The FIFO never overflows, so no stall signal goes to the macro.
- Latency: request fires in cycle N, resp_valid is first visible in cycle N+2.
- Throughput: 1 response/cycle when resp_ready is held high.
- Simultaneous push and pop on a full or partially filled FIFO: occ is unchanged and order is preserved.
- Push and pop on an empty FIFO: not possible, because a push lands at the edge and pop needs occ != 0.
- Back-pressure: with resp_ready=0, at most 2 requests are accepted before req_ready drops. Once occ=2, req_ready stays 0 until the first pop.
- resp_data and resp_valid stay stable while resp_valid && !resp_ready.
- Read/write collision: a write in cycle N+1 to the address read in cycle N does not affect that read; the captured data is the pre-write value. A write in cycle N-1 or earlier is always visible.
- Reset (reset=0 at an edge):
  - occ=0, inflight=0, FIFO pointers=0.
  - resp_valid=0; req_ready=1 in the cycle after reset deasserts.
  - An in-flight read at reset is discarded, and no response appears for it.
  - mem_*_en follow their inputs combinationally; the instantiating logic must hold req_valid and wr_valid low during reset.
- FIFO storage is not reset. Only valid/occupancy state is reset.

Optional Feature:
- Macro SRAM_RD_SAME_CYCLE_WR_BYPASS_EN.
- When defined: if fire && wr_valid && (wr_addr == req_addr) in cycle N, the block registers wr_data/wr_mask alongside the inflight flag. At capture, each byte with mask=1 is replaced by the registered write byte, giving guaranteed write-before-read semantics independent of the macro's read-during-write behaviour.
- When undefined: the response for a same-cycle same-address read returns whatever the macro yields, and the bench must not check that value.
- Latency and credit behaviour are identical with and without the macro.

Test Plan:
- Preload addr 0x005=0xDEADBEEF via the write port; 2 idle cycles; read 0x005 with resp_ready=1 -> resp_valid in cycle N+2, resp_data=0xDEADBEEF.
- Write 0x010 with 0x11223344 mask 4'b1111, then 0xAABBCCDD mask 4'b0101; read 0x010 -> resp_data=0x11BB33DD.
- Back-to-back reads of 0x000..0x00F with resp_ready=1 -> 16 in-order responses on consecutive cycles; req_ready never deasserts.
- resp_ready=0, req_valid=1 continuously -> exactly 2 fires, then req_ready=0 and occ=2 with resp_data held. Raise resp_ready -> the third request fires in the same cycle as the first pop.
- Fire read of 0x020, assert reset=0 the next cycle -> no resp_valid after reset; occ=0, req_ready=1.
- With SRAM_RD_SAME_CYCLE_WR_BYPASS_EN: 0x030 holds 0x00000000; same-cycle write 0xCAFEF00D mask 4'b0011 and read 0x030 -> resp_data=0x0000F00D.

Source files
------------

// File: rtl/sram_rd_resp_pipe.sv
// Valid/ready read front end and write pass-through for a 1024x32 byte-masked dual-port SRAM.
// Optional write-before-read bypass for same-cycle same-address traffic: SRAM_RD_SAME_CYCLE_WR_BYPASS_EN.
module sram_rd_resp_pipe #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned MASK_W = DATA_W / 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_data,
  input  logic              wr_valid,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [MASK_W-1:0] wr_mask,
  output logic              mem_W0_en,
  output logic [ADDR_W-1:0] mem_W0_addr,
  output logic [DATA_W-1:0] mem_W0_data,
  output logic [MASK_W-1:0] mem_W0_mask,
  output logic              mem_R0_en,
  output logic [ADDR_W-1:0] mem_R0_addr,
  input  logic [DATA_W-1:0] mem_R0_data
);

  localparam int unsigned FIFO_DEPTH = 2;
  localparam int unsigned OCC_W      = 2;
  localparam int unsigned CRED_W     = 3;

  logic              fire;
  logic              push;
  logic              pop;
  logic              inflight_q;
  logic [OCC_W-1:0]  occ_q;
  logic [OCC_W-1:0]  occ_d;
  logic              wr_ptr_q;
  logic              rd_ptr_q;
  logic [CRED_W-1:0] credit_used;
  logic [DATA_W-1:0] cap_data;
  logic [DATA_W-1:0] fifo_q [FIFO_DEPTH];

  // Write stream goes straight to the macro.
  assign mem_W0_en   = wr_valid;
  assign mem_W0_addr = wr_addr;
  assign mem_W0_data = wr_data;
  assign mem_W0_mask = wr_mask;

  // Read issue; macro registers the address at the end of the fire cycle.
  assign fire        = req_valid && req_ready;
  assign mem_R0_en   = fire;
  assign mem_R0_addr = req_addr;

  assign push       = inflight_q;
  assign resp_valid = (occ_q != OCC_W'(0));
  assign pop        = resp_valid && resp_ready;
  assign resp_data  = fifo_q[rd_ptr_q];

  // A slot freed by this cycle's pop can be reissued immediately.
  assign credit_used = CRED_W'(occ_q) + CRED_W'(inflight_q) - CRED_W'(pop);
  assign req_ready   = (credit_used < CRED_W'(FIFO_DEPTH));

  assign occ_d = occ_q + OCC_W'(push) - OCC_W'(pop);

`ifdef SRAM_RD_SAME_CYCLE_WR_BYPASS_EN
  logic              byp_hit_q;
  logic [DATA_W-1:0] byp_data_q;
  logic [MASK_W-1:0] byp_mask_q;

  always_ff @(posedge clock) begin
    if (!reset) begin
      byp_hit_q <= 1'b0;
    end else begin
      byp_hit_q <= fire && wr_valid && (wr_addr == req_addr);
    end
  end

  always_ff @(posedge clock) begin
    byp_data_q <= wr_data;
    byp_mask_q <= wr_mask;
  end

  // Overlay enabled bytes of the colliding write onto the macro read data.
  always_comb begin
    cap_data = mem_R0_data;
    for (int b = 0; b < int'(MASK_W); b++) begin
      if (byp_hit_q && byp_mask_q[b]) begin
        cap_data[b*8 +: 8] = byp_data_q[b*8 +: 8];
      end
    end
  end
`else
  assign cap_data = mem_R0_data;
`endif

  // Control state; an in-flight read is dropped by reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      inflight_q <= 1'b0;
      occ_q      <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
    end else begin
      inflight_q <= fire;
      occ_q      <= occ_d;
      if (push) wr_ptr_q <= ~wr_ptr_q;
      if (pop)  rd_ptr_q <= ~rd_ptr_q;
    end
  end

  // Data storage carries no reset.
  always_ff @(posedge clock) begin
    if (push) fifo_q[wr_ptr_q] <= cap_data;
  end

`ifndef SYNTHESIS
  a_credit_bound : assert property (@(posedge clock) disable iff (!reset)
    (CRED_W'(occ_q) + CRED_W'(inflight_q)) <= CRED_W'(FIFO_DEPTH));
`endif

endmodule

// File: tb/tb_sram_rd_resp_pipe.sv
// Directed bench for sram_rd_resp_pipe with a behavioural 1024x32 byte-masked SRAM model.
module tb_sram_rd_resp_pipe;

  localparam int unsigned ADDR_W = 10;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned MASK_W = 4;

  logic              clock = 1'b0;
  logic              reset;
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_data;
  logic              wr_valid;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [MASK_W-1:0] wr_mask;
  logic              mem_W0_en;
  logic [ADDR_W-1:0] mem_W0_addr;
  logic [DATA_W-1:0] mem_W0_data;
  logic [MASK_W-1:0] mem_W0_mask;
  logic              mem_R0_en;
  logic [ADDR_W-1:0] mem_R0_addr;
  logic [DATA_W-1:0] mem_R0_data;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clock = ~clock;

  sram_rd_resp_pipe #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MASK_W(MASK_W)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_mask(wr_mask),
    .mem_W0_en(mem_W0_en), .mem_W0_addr(mem_W0_addr), .mem_W0_data(mem_W0_data),
    .mem_W0_mask(mem_W0_mask), .mem_R0_en(mem_R0_en), .mem_R0_addr(mem_R0_addr),
    .mem_R0_data(mem_R0_data)
  );

  // SRAM macro model: masked write at the edge, registered read address.
  logic [DATA_W-1:0] sram [1024];
  logic [ADDR_W-1:0] raddr_q = '0;

  always @(posedge clock) begin
    if (mem_W0_en) begin
      for (int b = 0; b < int'(MASK_W); b++)
        if (mem_W0_mask[b]) sram[mem_W0_addr][b*8 +: 8] <= mem_W0_data[b*8 +: 8];
    end
    if (mem_R0_en) raddr_q <= mem_R0_addr;
  end
  assign mem_R0_data = sram[raddr_q];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one cycle; inputs driven after this settle before the next edge.
  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  function automatic logic [31:0] pat(input int i);
    return 32'hA500_0000 | 32'(i * 32'h0101);
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; req_valid = 1'b0; req_addr = '0; resp_ready = 1'b0;
    wr_valid = 1'b0; wr_addr = '0; wr_data = '0; wr_mask = '0;
    repeat (3) cyc();
    reset = 1'b1;
    cyc();
    settle();
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd1);

    // Preload 0x005 and check write pass-through.
    wr_valid = 1'b1; wr_addr = 10'h005; wr_data = 32'hDEADBEEF; wr_mask = 4'hF;
    settle();
    check("w0_en", 32'(mem_W0_en), 32'd1);
    check("w0_addr", 32'(mem_W0_addr), 32'h005);
    check("w0_data", mem_W0_data, 32'hDEADBEEF);
    check("w0_mask", 32'(mem_W0_mask), 32'hF);
    cyc();
    wr_valid = 1'b0;
    cyc(); cyc();

    // Single read, two-cycle latency.
    req_valid = 1'b1; req_addr = 10'h005; resp_ready = 1'b1;
    settle();
    check("rd1_ready", 32'(req_ready), 32'd1);
    check("rd1_r0_en", 32'(mem_R0_en), 32'd1);
    check("rd1_r0_addr", 32'(mem_R0_addr), 32'h005);
    cyc();
    req_valid = 1'b0;
    settle();
    check("rd1_n1_valid", 32'(resp_valid), 32'd0);
    cyc();
    check("rd1_n2_valid", 32'(resp_valid), 32'd1);
    check("rd1_n2_data", resp_data, 32'hDEADBEEF);
    cyc();
    check("rd1_n3_valid", 32'(resp_valid), 32'd0);

    // Masked overwrite of 0x010.
    wr_valid = 1'b1; wr_addr = 10'h010; wr_data = 32'h11223344; wr_mask = 4'b1111;
    cyc();
    wr_data = 32'hAABBCCDD; wr_mask = 4'b0101;
    cyc();
    wr_valid = 1'b0;
    req_valid = 1'b1; req_addr = 10'h010;
    cyc();
    req_valid = 1'b0;
    cyc();
    check("mask_valid", 32'(resp_valid), 32'd1);
    check("mask_data", resp_data, 32'h11BB33DD);
    cyc();

    // Write in N+1 to the address read in N leaves the read unaffected.
    req_valid = 1'b1; req_addr = 10'h010;
    cyc();
    req_valid = 1'b0;
    wr_valid = 1'b1; wr_addr = 10'h010; wr_data = 32'h0; wr_mask = 4'hF;
    cyc();
    wr_valid = 1'b0;
    settle();
    check("coll_data", resp_data, 32'h11BB33DD);
    cyc();

    // Preload 0x000..0x00F then stream reads back to back.
    for (int i = 0; i < 16; i++) begin
      wr_valid = 1'b1; wr_addr = ADDR_W'(i); wr_data = pat(i); wr_mask = 4'hF;
      cyc();
    end
    wr_valid = 1'b0;
    cyc();
    for (int k = 0; k < 18; k++) begin
      req_valid = (k < 16);
      req_addr  = ADDR_W'(k);
      settle();
      if (k < 16) check($sformatf("stream_ready_%0d", k), 32'(req_ready), 32'd1);
      if (k >= 2) begin
        check($sformatf("stream_valid_%0d", k - 2), 32'(resp_valid), 32'd1);
        check($sformatf("stream_data_%0d", k - 2), resp_data, pat(k - 2));
      end
      cyc();
    end
    req_valid = 1'b0;
    settle();
    check("stream_drained", 32'(resp_valid), 32'd0);

    // Back-pressure: two fires, then held full until the first pop.
    resp_ready = 1'b0;
    req_valid = 1'b1; req_addr = 10'h000;
    settle();
    check("bp_fire0", 32'(req_ready), 32'd1);
    cyc();
    req_addr = 10'h001;
    settle();
    check("bp_fire1", 32'(req_ready), 32'd1);
    cyc();
    req_addr = 10'h002;
    settle();
    check("bp_stall_a", 32'(req_ready), 32'd0);
    for (int k = 0; k < 3; k++) begin
      cyc();
      settle();
      check($sformatf("bp_stall_%0d", k), 32'(req_ready), 32'd0);
      check($sformatf("bp_valid_%0d", k), 32'(resp_valid), 32'd1);
      check($sformatf("bp_hold_%0d", k), resp_data, pat(0));
    end
    resp_ready = 1'b1;
    settle();
    check("bp_refire", 32'(req_ready), 32'd1);
    check("bp_pop0", resp_data, pat(0));
    cyc();
    req_valid = 1'b0;
    settle();
    check("bp_pop1", resp_data, pat(1));
    cyc();
    check("bp_pop2_valid", 32'(resp_valid), 32'd1);
    check("bp_pop2", resp_data, pat(2));
    cyc();
    check("bp_empty", 32'(resp_valid), 32'd0);

    // Reset while a read is in flight discards it.
    req_valid = 1'b1; req_addr = 10'h020;
    cyc();
    req_valid = 1'b0;
    reset = 1'b0;
    cyc(); cyc();
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cyc();
      settle();
      check($sformatf("rstfl_valid_%0d", k), 32'(resp_valid), 32'd0);
      check($sformatf("rstfl_ready_%0d", k), 32'(req_ready), 32'd1);
    end

`ifdef SRAM_RD_SAME_CYCLE_WR_BYPASS_EN
    // Same-cycle write and read of 0x030.
    wr_valid = 1'b1; wr_addr = 10'h030; wr_data = 32'h0; wr_mask = 4'hF;
    cyc();
    wr_valid = 1'b0;
    cyc();
    wr_valid = 1'b1; wr_data = 32'hCAFEF00D; wr_mask = 4'b0011;
    req_valid = 1'b1; req_addr = 10'h030;
    cyc();
    wr_valid = 1'b0; req_valid = 1'b0;
    cyc();
    check("byp_valid", 32'(resp_valid), 32'd1);
    check("byp_data", resp_data, 32'h0000F00D);
    cyc();
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
